// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared constants for the timekeeping core
//
// Mode encoding of clk_mode, BCD limits of the two-digit counters and the
// power-on alarm time.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2,
        MODE_CONFIG    = 2'd3
    } mode_e;

    localparam int MIN_MODULO  = 60;
    localparam int HOUR_MODULO = 24;

    localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
    localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

    localparam logic [15:0] ALARM_RESET = 16'h0600;

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter with carry and clear
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (loads RESET_VAL)
//   clr          synchronous clear to 00, wins over inc
//   inc          advance by one this cycle
//   value        current count, {tens, units} BCD
//   next_value   value that will be loaded on the next edge
//   carry        high in the cycle an increment wraps MODULO-1 -> 00
module bcd_mod_counter #(
    parameter int         MODULO    = 60,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] value,
    output logic [7:0] next_value,
    output logic       carry
);

    localparam logic [3:0] MAX_TENS  = 4'((MODULO - 1) / 10);
    localparam logic [3:0] MAX_UNITS = 4'((MODULO - 1) % 10);

    always_comb begin
        carry      = inc && !clr && (value == {MAX_TENS, MAX_UNITS});
        next_value = value;
        if (clr) begin
            next_value = 8'h00;
        end else if (inc) begin
            if (carry) begin
                next_value = 8'h00;
            end else if (value[3:0] == 4'd9) begin
                next_value = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next_value = {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= RESET_VAL;
        end else begin
            value <= next_value;
        end
    end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour BCD clock with settable time, alarm and ring
//
// Ports:
//   mclk        main clock, MFREQ_KHZ kHz
//   rst         asynchronous active-low reset
//   clk_mode    0 run, 1 set time, 2 set alarm, 3 config
//   vButton     one-cycle presses: [0] minutes / toggle, [1] hours
//   time_bcd    {H1,H0,M1,M0,S1,S0}
//   alarm_bcd   {H1,H0,M1,M0}
//   alarm_en    alarm armed
//   alarm_ring  high while ringing
//   sec_tick    one-cycle pulse in the cycle a new time_bcd first shows
module time_keeper
    import clock_pkg::*;
#(
    parameter int MFREQ_KHZ = 1,
    parameter int RING_SEC  = 60
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic [1:0]  clk_mode,
    input  logic [1:0]  vButton,
    output logic [23:0] time_bcd,
    output logic [15:0] alarm_bcd,
    output logic        alarm_en,
    output logic        alarm_ring,
    output logic        sec_tick
);

    localparam logic [31:0] PRESC_TC  = 32'(MFREQ_KHZ * 1000 - 1);
    localparam logic [7:0]  RING_LOAD = 8'(RING_SEC);

    logic [31:0] presc;
    logic [1:0]  prev_mode;
    logic [7:0]  ring_cnt;

    logic in_set_time, in_set_alarm, in_config;
    logic leave_set_time, enter_set_time;
    logic advance, trigger, ring_stop;

    logic [7:0] sec_val, min_val, hr_val, amin_val, ahr_val;
    logic [7:0] sec_next, min_next, hr_next, amin_next, ahr_next;
    logic       sec_carry, min_carry, hr_carry, amin_carry, ahr_carry;
    logic       unused_bits;

    assign in_set_time    = (clk_mode == MODE_SET_TIME);
    assign in_set_alarm   = (clk_mode == MODE_SET_ALARM);
    assign in_config      = (clk_mode == MODE_CONFIG);
    assign leave_set_time = (prev_mode == MODE_SET_TIME) && !in_set_time;
    assign enter_set_time = in_set_time && (prev_mode != MODE_SET_TIME);

    // The prescaler is parked at 0 while setting time, so the first advance
    // after leaving set-time mode is a full second later.
    assign advance = !in_set_time && (presc == PRESC_TC);

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            presc     <= '0;
            prev_mode <= MODE_RUN;
            sec_tick  <= 1'b0;
        end else begin
            prev_mode <= clk_mode;
            sec_tick  <= advance;
            if (in_set_time || leave_set_time || advance) begin
                presc <= '0;
            end else begin
                presc <= presc + 32'd1;
            end
        end
    end

    // Time chain. Carries only cascade on a real advance, so a minutes
    // wrap made by a button press never touches the hours.
    bcd_mod_counter #(.MODULO(MIN_MODULO), .RESET_VAL(8'h00)) u_sec (
        .clk(mclk), .rst_n(rst), .clr(leave_set_time), .inc(advance),
        .value(sec_val), .next_value(sec_next), .carry(sec_carry)
    );

    bcd_mod_counter #(.MODULO(MIN_MODULO), .RESET_VAL(8'h00)) u_min (
        .clk(mclk), .rst_n(rst), .clr(1'b0),
        .inc(sec_carry || (in_set_time && vButton[0])),
        .value(min_val), .next_value(min_next), .carry(min_carry)
    );

    bcd_mod_counter #(.MODULO(HOUR_MODULO), .RESET_VAL(8'h00)) u_hr (
        .clk(mclk), .rst_n(rst), .clr(1'b0),
        .inc((sec_carry && min_carry) || (in_set_time && vButton[1])),
        .value(hr_val), .next_value(hr_next), .carry(hr_carry)
    );

    bcd_mod_counter #(.MODULO(MIN_MODULO), .RESET_VAL(ALARM_RESET[7:0])) u_amin (
        .clk(mclk), .rst_n(rst), .clr(1'b0),
        .inc(in_set_alarm && vButton[0]),
        .value(amin_val), .next_value(amin_next), .carry(amin_carry)
    );

    bcd_mod_counter #(.MODULO(HOUR_MODULO), .RESET_VAL(ALARM_RESET[15:8])) u_ahr (
        .clk(mclk), .rst_n(rst), .clr(1'b0),
        .inc(in_set_alarm && vButton[1]),
        .value(ahr_val), .next_value(ahr_next), .carry(ahr_carry)
    );

    assign time_bcd  = {hr_val, min_val, sec_val};
    assign alarm_bcd = {ahr_val, amin_val};

    // Hour carries and the look-ahead of the non-compared counters are
    // intentionally left unused.
    assign unused_bits = ^{hr_carry, amin_carry, ahr_carry, sec_next, amin_next, ahr_next};

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            alarm_en <= 1'b0;
        end else if (in_config && vButton[0]) begin
            alarm_en <= !alarm_en;
        end
    end

    // Match is judged on the value the advance is about to load: seconds
    // wrapping to 00 and the look-ahead minutes/hours equal to the alarm.
    assign trigger   = advance && sec_carry && alarm_en &&
                       ({hr_next, min_next} == alarm_bcd);
    assign ring_stop = (|vButton) || enter_set_time || !alarm_en;

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else if (ring_stop) begin
            alarm_ring <= 1'b0;
            ring_cnt   <= '0;
        end else if (trigger) begin
            alarm_ring <= 1'b1;
            ring_cnt   <= RING_LOAD;
        end else if (alarm_ring && advance) begin
            if (ring_cnt <= 8'd1) begin
                alarm_ring <= 1'b0;
                ring_cnt   <= '0;
            end else begin
                ring_cnt <= ring_cnt - 8'd1;
            end
        end
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Timekeeping core that consumes the button controller's decoded outputs, `clk_mode` and the one-cycle `vButton` pulses. It keeps a 24-hour HH:MM:SS time, runs from a 1 Hz tick prescaled from `mclk`, lets the user set the time and alarm with the digit buttons, and raises an alarm ring output. It sits between the button controller and the display/buzzer drivers. All outputs are BCD and ready for digit display.

## Interface
- `MFREQ_KHZ`, default 1: `mclk` frequency in kHz; one second = MFREQ_KHZ*1000 cycles.
- `RING_SEC`, default 60: alarm ring duration in seconds (1..255).

- `mclk`  in  1  main clock
- `rst`  in  1  asynchronous, active-low reset
- `clk_mode`  in  2  0 run, 1 set time, 2 set alarm, 3 config
- `vButton`  in  2  one-cycle pulses; [0] units/minutes button, [1] tens/hours button
- `time_bcd`  out  24  {H1,H0,M1,M0,S1,S0}, 4 bits per digit
- `alarm_bcd`  out  16  {H1,H0,M1,M0}
- `alarm_en`  out  1  alarm armed
- `alarm_ring`  out  1  high while ringing
- `sec_tick`  out  1  one-cycle pulse on each time advance

## Operation
- Reset values:
  - `time_bcd` = 0x000000.
  - `alarm_bcd` = 0x0600.
  - `alarm_en`, `alarm_ring`, `sec_tick` = 0.
  - Prescaler = 0; ring counter = 0.
- Prescaler:
  - 32-bit counter, 0..MFREQ_KHZ*1000-1.
  - At terminal count it wraps to 0 and time advances one second.
- Time advance:
  - Happens in modes 0, 2 and 3. Mode 1 freezes time and holds the prescaler at 0.
  - Seconds 59->00 carries to minutes; minutes 59->00 carries to hours; 23:59:59 -> 00:00:00.
- Mode 1 (set time):
  - `vButton[0]`: minutes +1, 59->00, no carry to hours.
  - `vButton[1]`: hours +1, 23->00.
  - Leaving mode 1 (1 -> any other mode) clears seconds to 00 and restarts the prescaler from 0.
- Mode 2 (set alarm): same increment and wrap rules, applied to `alarm_bcd`. Time keeps running.
- Mode 3 (config): `vButton[0]` toggles `alarm_en`; `vButton[1]` is ignored.
- Mode 0 (run): `vButton` does not edit anything.
- Both `vButton` bits in the same cycle: both actions are applied.
- Alarm trigger:
  - Fires on a time advance whose new value is HH:MM:00 equal to `alarm_bcd`, with `alarm_en` = 1.
  - Result: `alarm_ring` <= 1 and ring counter <= RING_SEC.
  - Edits in mode 1 or 2 never trigger, even if they create a match.
- Ring termination, first of:
  - Ring counter reaching 0; it decrements on each time advance while ringing.
  - Any `vButton` pulse in any mode. The press also performs its normal mode action.
  - `alarm_en` going to 0.
  - Entering mode 1.
- A trigger during an active ring reloads the counter.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

## Timing
- `vButton` pulse sampled at edge N: the register update is visible after edge N.
- `sec_tick` is registered. It is high for exactly the one cycle in which the new `time_bcd` is first visible.
- `alarm_ring` rises on the same edge as the `sec_tick` that produces the match.
- `alarm_ring` falls on the edge after a terminating button pulse is sampled, or on the `sec_tick` edge where the counter reaches 0.
- Mode change at edge N takes effect for actions sampled at edge N+1.
- Mode 1 exit: the first advance after exit occurs MFREQ_KHZ*1000 cycles later.
- Time advance and a `vButton` edit in the same cycle (mode 2): both apply; they touch different registers.

## Structure
- Shared package `clock_pkg` holds:
  - Mode constants MODE_RUN=0, MODE_SET_TIME=1, MODE_SET_ALARM=2, MODE_CONFIG=3.
  - BCD limit constants (59, 23).
  - Reset constant for the alarm time (0x0600).
- Sub-module `bcd_mod_counter` (parameter MODULO):
  - Two-digit BCD counter with `inc` input and a `carry` output that pulses on wrap.
  - Instantiated for seconds, minutes and hours, and for alarm minutes and hours.
  - Also has a synchronous clear input, used for the seconds clear on mode 1 exit.

## Test plan
All scenarios use MFREQ_KHZ=1 and RING_SEC=3.
- Reset then 1000 cycles in mode 0 -> `sec_tick` pulses once at cycle 1000 and `time_bcd` = 0x000001.
- Set time to 23:59 in mode 1, return to mode 0, wait 60 s -> `time_bcd` = 0x000000 and the hours wrap has no side effects.
- In mode 1, issue 61 `vButton[0]` pulses from 00 -> minutes = 01 and hours unchanged. Issue `vButton[0]` and `vButton[1]` in the same cycle -> both increment.
- Alarm set to 00:01 and enabled via mode 3, time run from 00:00:00 -> `alarm_ring` rises with the `sec_tick` producing 0x000100 and falls after 3 further ticks.
- Ringing, then one `vButton[1]` pulse in mode 0 -> `alarm_ring` is 0 the next cycle and time is unchanged.
- Assert `rst` low mid-ring and mid-prescale -> all outputs take reset values immediately; after release the first tick comes 1000 cycles later.
